// File: rtl/dev_bus_pkg.sv
// rtl/dev_bus_pkg.sv - shared types and constants for the CPU-to-device bridge
// Contents: FSM state encoding, default device windows, ERRCNT register
// offset, device-select encoding and the one-hot to select conversion.
package dev_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [31:0] DEV0_BASE_DEF = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE_DEF = 32'h0000_7F10;
    localparam logic [31:0] DEV2_BASE_DEF = 32'h0000_7F20;
    localparam int          DEV_SPAN_DEF  = 12;

    // ERRCNT register sits this far above the DEV2 window base.
    localparam logic [31:0] ERRCNT_OFFSET = 32'h0000_0010;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_D0,
        SEL_D1,
        SEL_D2,
        SEL_ERRCNT
    } dev_sel_e;

    // hit bit order: [0]=DEV0, [1]=DEV1, [2]=DEV2, [3]=ERRCNT register
    function automatic dev_sel_e sel_from_hit(input logic [3:0] hit);
        dev_sel_e sel;
        sel = SEL_NONE;
        if (hit[0])      sel = SEL_D0;
        else if (hit[1]) sel = SEL_D1;
        else if (hit[2]) sel = SEL_D2;
        else if (hit[3]) sel = SEL_ERRCNT;
        return sel;
    endfunction

endpackage

// File: rtl/dev_addr_decode.sv
// rtl/dev_addr_decode.sv - combinational byte address to one-hot device select
// Ports: addr (32-bit byte address) in; hit[3:0] one-hot out,
// [0]=DEV0, [1]=DEV1, [2]=DEV2, [3]=ERRCNT register (only when ERRCNT_EN).
module dev_addr_decode
    import dev_bus_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
    parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF,
    parameter logic [31:0] DEV2_BASE = DEV2_BASE_DEF,
    parameter int          DEV_SPAN  = DEV_SPAN_DEF,
    parameter bit          ERRCNT_EN = 1'b0
) (
    input  logic [31:0] addr,
    output logic [3:0]  hit
);

    localparam logic [31:0] SPAN_LAST = 32'(DEV_SPAN) - 32'd1;

    // Windows are inclusive on both ends: BASE .. BASE+DEV_SPAN-1.
    always_comb begin
        hit    = 4'b0000;
        hit[0] = (addr >= DEV0_BASE) && (addr <= DEV0_BASE + SPAN_LAST);
        hit[1] = (addr >= DEV1_BASE) && (addr <= DEV1_BASE + SPAN_LAST);
        hit[2] = (addr >= DEV2_BASE) && (addr <= DEV2_BASE + SPAN_LAST);
        hit[3] = ERRCNT_EN && (addr == DEV2_BASE + ERRCNT_OFFSET);
    end

endmodule

// File: rtl/dev_bridge.sv
// rtl/dev_bridge.sv - CPU load/store to peripheral device bus bridge
// Ports: clk, reset (sync, active-high); CPU side cpu_req/cpu_we/cpu_addr/
// cpu_wd in, cpu_rd/cpu_ack/cpu_err out; device side DEV_Addr/DEV_WD/DEVn_WE
// out, DEVn_RD in; intrp0..2 in, HWInt[5:0] registered out.
// Optional macro BRIDGE_ERRCNT_EN adds the unmapped-access counter at DEV2_BASE+16.
module dev_bridge
    import dev_bus_pkg::*;
#(
    parameter logic [31:0] DEV0_BASE   = DEV0_BASE_DEF,
    parameter logic [31:0] DEV1_BASE   = DEV1_BASE_DEF,
    parameter logic [31:0] DEV2_BASE   = DEV2_BASE_DEF,
    parameter int          DEV_SPAN    = DEV_SPAN_DEF,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] DEV_Addr,
    output logic [31:0] DEV_WD,
    output logic        DEV0_WE,
    output logic        DEV1_WE,
    output logic        DEV2_WE,
    input  logic [31:0] DEV0_RD,
    input  logic [31:0] DEV1_RD,
    input  logic [31:0] DEV2_RD,
    input  logic        intrp0,
    input  logic        intrp1,
    input  logic        intrp2,
    output logic [5:0]  HWInt
);

`ifdef BRIDGE_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wd_q, rd_q, rd_mux;
    logic        we_q;
    dev_sel_e    sel_q;
    logic [3:0]  wait_q;
    logic [5:0]  hwint_q;
    logic [3:0]  hit;
    logic [7:0]  err_cnt;

    dev_addr_decode #(
        .DEV0_BASE (DEV0_BASE),
        .DEV1_BASE (DEV1_BASE),
        .DEV2_BASE (DEV2_BASE),
        .DEV_SPAN  (DEV_SPAN),
        .ERRCNT_EN (ERRCNT_EN)
    ) u_decode (
        .addr (cpu_addr),
        .hit  (hit)
    );

    // Data presented in RESP; stores and unmapped accesses return zero.
    always_comb begin
        rd_mux = 32'h0;
        if (!we_q) begin
            case (sel_q)
                SEL_D0:     rd_mux = DEV0_RD;
                SEL_D1:     rd_mux = DEV1_RD;
                SEL_D2:     rd_mux = DEV2_RD;
                SEL_ERRCNT: rd_mux = {24'h0, err_cnt};
                default:    rd_mux = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cpu_req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT:   if (wait_q == 4'd0) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobe and response outputs are gated by reset so an aborted access
    // never shows a strobe or ack in the cycle reset is asserted.
    always_comb begin
        DEV0_WE = 1'b0;
        DEV1_WE = 1'b0;
        DEV2_WE = 1'b0;
        cpu_ack = 1'b0;
        cpu_err = 1'b0;
        cpu_rd  = 32'h0;
        if (!reset) begin
            if (state_q == ST_ACCESS && we_q) begin
                DEV0_WE = (sel_q == SEL_D0);
                DEV1_WE = (sel_q == SEL_D1);
                DEV2_WE = (sel_q == SEL_D2);
            end
            if (state_q == ST_RESP) begin
                cpu_ack = 1'b1;
                cpu_err = (sel_q == SEL_NONE);
                cpu_rd  = rd_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            wd_q    <= 32'h0;
            we_q    <= 1'b0;
            sel_q   <= SEL_NONE;
            wait_q  <= 4'd0;
            rd_q    <= 32'h0;
            hwint_q <= 6'b0;
        end else begin
            state_q <= state_d;
            hwint_q <= {3'b000, intrp2, intrp1, intrp0};
            if (state_q == ST_IDLE && cpu_req) begin
                addr_q <= cpu_addr;
                wd_q   <= cpu_wd;
                we_q   <= cpu_we;
                sel_q  <= sel_from_hit(hit);
            end
            if (state_q == ST_ACCESS) begin
                wait_q <= WAIT_LOAD;
            end else if (state_q == ST_WAIT && wait_q != 4'd0) begin
                wait_q <= wait_q - 4'd1;
            end
            // Capture read data at the end of the cycle before RESP.
            if (state_d == ST_RESP) begin
                rd_q <= rd_mux;
            end
        end
    end

`ifdef BRIDGE_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= 8'h00;
        end else if (state_q == ST_RESP) begin
            if (sel_q == SEL_NONE && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end else if (sel_q == SEL_ERRCNT && we_q) begin
                err_cnt <= 8'h00;
            end
        end
    end
`else
    assign err_cnt = 8'h00;
`endif

    assign DEV_Addr = addr_q;
    assign DEV_WD   = wd_q;
    assign HWInt    = hwint_q;

endmodule

// File: doc/dev_bridge.md
Name: dev_bridge

Overview:
- CPU-side initiator of the peripheral device bus: turns one CPU load/store request into a device access with a one-cycle write strobe.
- Decodes the address to one of three devices, captures read data and returns it with an acknowledge.
- Registers device interrupt lines into the HWInt vector for CP0.
- Sits between the MEM stage and DEV0 (timer/counter), DEV1 and DEV2.

Parameters:
- DEV0_BASE, 32'h0000_7F00, base of device 0 window
- DEV1_BASE, 32'h0000_7F10, base of device 1 window
- DEV2_BASE, 32'h0000_7F20, base of device 2 window
- DEV_SPAN, 12, window size in bytes; valid offsets are 0..DEV_SPAN-1
- WAIT_CYCLES, 0, extra wait cycles between strobe and data capture (0..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cpu_req  in  1  request valid; held until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wd  in  32  store data
- cpu_rd  out  32  load data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  unmapped access; valid with cpu_ack
- DEV_Addr  out  32  device address (offset not subtracted)
- DEV_WD  out  32  device write data
- DEV0_WE, DEV1_WE, DEV2_WE  out  1 each  device write strobes
- DEV0_RD, DEV1_RD, DEV2_RD  in  32 each  device read data
- intrp0, intrp1, intrp2  in  1 each  device interrupt lines
- HWInt  out  6  {3'b000, intrp2, intrp1, intrp0}, registered

Behaviour:
- Reset (synchronous, active-high) clears every output: cpu_rd=0, cpu_ack=0, cpu_err=0, DEV_Addr=0, DEV_WD=0, all DEVn_WE=0, HWInt=0. The FSM goes to IDLE and all captured request state is cleared.
- Reset mid-access aborts the access: no ack and no strobe in the reset cycle or the cycle after it.
- FSM states and transitions:
  - IDLE: if cpu_req, latch cpu_addr, cpu_wd, cpu_we and the decoded device select, then go to ACCESS.
  - ACCESS (1 cycle): drive DEV_Addr and DEV_WD from the latches. DEVn_WE=1 only for the selected device and only if the request is a store. Go to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: down-counter loaded with WAIT_CYCLES-1; go to RESP when it reaches 0. All DEVn_WE=0.
  - RESP (1 cycle): cpu_ack=1. For a load, cpu_rd = the selected DEVn_RD sampled at the end of the previous cycle; for a store, cpu_rd=0. Return to IDLE.
- Latency from a cpu_req that is high in IDLE to cpu_ack is 2+WAIT_CYCLES cycles.
- The earliest next request is accepted in the cycle after RESP; back-to-back accesses therefore take 3+WAIT_CYCLES cycles each.
- cpu_req is ignored outside IDLE. A request that drops before ack is still completed once started.
- Address decode: a device is hit when BASE <= addr <= BASE+DEV_SPAN-1 (32-bit unsigned compare). Windows never overlap.
- Alignment: addr[1:0] is passed through unchanged; devices ignore it.
- Unmapped access: no strobe is issued; RESP still occurs with cpu_err=1 and cpu_rd=0.
- DEV_Addr and DEV_WD hold their last values between accesses; they change only on leaving IDLE.
- HWInt: each bit is a flop of the corresponding intrp line, so an interrupt is visible one cycle after it rises. Bits [5:3] are always 0.

Optional Feature:
- Macro: BRIDGE_ERRCNT_EN.
- Defined:
  - An 8-bit saturating counter increments on every unmapped access (at RESP) and holds at 8'hFF.
  - Address DEV2_BASE+16 (32'h7F30) is an internal register. A load there returns {24'b0, count} with cpu_err=0; a store there clears the counter.
  - No device strobe is issued for 0x7F30 accesses.
  - Reset clears the counter.
- Not defined: no counter exists, and 0x7F30 is unmapped like any other unmapped address.

Decomposition:
- Shared package dev_bus_pkg holds:
  - the FSM state encoding (IDLE, ACCESS, WAIT, RESP);
  - the default base addresses and DEV_SPAN;
  - the ERRCNT register offset;
  - the device-select encoding (NONE, D0, D1, D2, ERRCNT).
- One sub-module, dev_addr_decode: combinational address to one-hot select. It is reused by the test bench scoreboard.
- FSM, latches and HWInt register stay in dev_bridge.

Test Plan:
- Store 32'h0000_0009 to 0x7F00, WAIT_CYCLES=0 -> DEV0_WE=1 for exactly one cycle with DEV_Addr=0x7F00 and DEV_WD=9; cpu_ack two cycles after request; cpu_err=0; DEV1_WE and DEV2_WE stay 0.
- Load 0x7F14 with DEV1_RD=32'hDEAD_BEEF, WAIT_CYCLES=2 -> no WE; cpu_ack four cycles after request; cpu_rd=32'hDEAD_BEEF.
- Load 0x7F0C (just past DEV0) and store to 0x1000 -> no strobes; each access acks with cpu_err=1 and cpu_rd=0. With BRIDGE_ERRCNT_EN defined, a load of 0x7F30 then returns 2; store to 0x7F30 then load -> 0.
- intrp0 pulse of one cycle, intrp2 held high -> HWInt=6'b000001 for one cycle (one cycle delayed); HWInt[2] high from the cycle after intrp2 rises; HWInt[5:3] always 0.
- Assert reset during ACCESS of a store to 0x7F20 -> DEV2_WE=0 from the reset cycle on; no cpu_ack; FSM in IDLE; a new request after reset completes normally.
- Two back-to-back loads with cpu_req held high -> acks spaced 3 cycles apart (WAIT_CYCLES=0); the second access uses the address latched at its own IDLE.
